// File: rtl/fifo_ext_pkg.sv
// Shared types and helpers for the extended flop-based FIFO.
package fifo_ext_pkg;

    // Read-data presentation mode.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width for a given depth, never less than one bit.
    function automatic int ptr_w(input int d);
        int w;
        w = $clog2(d);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_ext_ctrl.sv
// Pointer, occupancy, acceptance, status and error-flag control for fifo_flops_ext.
module fifo_ext_ctrl
    import fifo_ext_pkg::*;
#(
    parameter int depth = 8,
    parameter int af_th = depth - 2,
    parameter int ae_th = 1,
    parameter int PW    = ptr_w(depth),
    parameter int CW    = $clog2(depth + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic          push_ok,
    output logic          pop_ok,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          pndng,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
    localparam logic [CW-1:0] AF_C     = CW'(af_th);
    localparam logic [CW-1:0] AE_C     = CW'(ae_th);

    // Pointers wrap at depth-1, so depth need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Acceptance from pre-edge occupancy; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count < DEPTH_C) || pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Status flags decoded purely from the registered count.
    always_comb begin
        full         = (count == DEPTH_C);
        pndng        = (count != '0);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) overflow <= 1'b1;
            else if (clr_err)     overflow <= 1'b0;
            if (pop && !pop_ok)   underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_flops_ext.sv
// Flop-based synchronous FIFO with occupancy, thresholds, sticky errors and selectable read mode.
module fifo_flops_ext
    import fifo_ext_pkg::*;
#(
    parameter int bits  = 16,
    parameter int depth = 8,
    parameter int af_th = depth - 2,
    parameter int ae_th = 1,
    parameter int fwft  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [bits-1:0]            Din,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [bits-1:0]            Dout,
    output logic                       full,
    output logic                       pndng,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int         PW   = ptr_w(depth);
    localparam int         CW   = $clog2(depth + 1);
    localparam fifo_mode_e MODE = (fwft != 0) ? FIFO_FWFT : FIFO_STD;

    logic [bits-1:0] mem [depth];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    fifo_ext_ctrl #(
        .depth (depth),
        .af_th (af_th),
        .ae_th (ae_th),
        .PW    (PW),
        .CW    (CW)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .clr_err      (clr_err),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .push_ok      (push_ok),
        .pop_ok       (pop_ok),
        .count        (count),
        .full         (full),
        .pndng        (pndng),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= Din;
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word shown directly from registered state; zero while empty.
            always_comb begin
                Dout = pndng ? mem[rd_ptr] : '0;
            end
        end else begin : g_std
            logic [bits-1:0] dout_q;
            // Registered read: capture the head word on an accepted pop, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst)         dout_q <= '0;
                else if (pop_ok) dout_q <= mem[rd_ptr];
            end
            assign Dout = dout_q;
        end
    endgenerate

endmodule

// File: doc/fifo_flops_ext.md
# fifo_flops_ext

Parametrised successor to `fifo_flops`: a flop-based synchronous FIFO with configurable width, depth and read mode, standard (registered) or first-word-fall-through. It adds:
- occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags.

It keeps the `fifo_flops` port names, so it drops into the existing `fifo_if`-based environment with the interface extended for the new signals.

## Interface
Parameters:
- `bits`, 16: data width, ≥1.
- `depth`, 8: number of entries, ≥2.
- `af_th`, depth-2: `almost_full` asserts when count ≥ `af_th`; range 1..depth.
- `ae_th`, 1: `almost_empty` asserts when count ≤ `ae_th`; range 0..depth-1.
- `fwft`, 0: 0 = standard registered read, 1 = first-word-fall-through.

Ports (CW = $clog2(depth+1)):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Din`  in  bits  write data.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `clr_err`  in  1  clears the sticky error flags.
- `Dout`  out  bits  read data.
- `full`  out  1  count == depth.
- `pndng`  out  1  count != 0.
- `almost_full`  out  1  count ≥ af_th.
- `almost_empty`  out  1  count ≤ ae_th.
- `count`  out  CW  current occupancy.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation
- State: storage `mem[depth]`, `wr_ptr` and `rd_ptr` (each wraps depth-1→0, depth need not be a power of 2), registered `count`.
- Acceptance, evaluated on pre-edge state:
  - pop_ok = pop && count≠0.
  - push_ok = push && (count<depth || pop_ok).
- Accepted push: writes `mem[wr_ptr]` ← `Din`, then advances `wr_ptr`.
- Accepted pop: advances `rd_ptr`.
- Count update: count += push_ok − pop_ok.
- Full with push and pop together: both accepted, count unchanged.
- Empty with push and pop together: push accepted, pop rejected, count becomes 1, `underflow` sets.
- Read modes:
  - fwft=0: on pop_ok, `Dout` ← `mem[rd_ptr]` at that edge; otherwise `Dout` holds its value.
  - fwft=1: `Dout` = `mem[rd_ptr]` whenever `pndng`, else 0. The value is combinational from registered state, and pop consumes the displayed word.
- Status outputs `full`, `pndng`, `almost_full`, `almost_empty` are decoded from the registered `count` only.
- Error flags:
  - `overflow` sets on push && !push_ok.
  - `underflow` sets on pop && !pop_ok.
  - Both clear on `clr_err`; if a set condition occurs in the same cycle, set wins.
- Reset (synchronous; `rst` overrides all other inputs in that cycle):
  - pointers, `count`, `Dout` = 0;
  - `full` = 0, `pndng` = 0, `almost_full` = 0, `almost_empty` = 1;
  - `overflow` = 0, `underflow` = 0.
  - `mem` contents are not cleared.
  - A reset asserted mid-stream discards all contents; the first push after reset reads back first.

## Timing
- Write-to-visible latency:
  - fwft=1: a word pushed at edge N appears on `Dout` in the cycle after edge N, if it is at the head.
  - fwft=0: the word appears one edge after the pop that requests it.
- Status outputs and `count` update at the same edge as the push/pop that changes them.
- Error flags are visible the cycle after the offending request.
- No combinational path from `push`/`pop` to any output.
- Throughput: one push and one pop per cycle, sustained, at any fill level from 1 to depth-1.

## Structure
- Package `fifo_ext_pkg` holds:
  - enum `fifo_mode_e` {FIFO_STD, FIFO_FWFT};
  - function `ptr_w(depth)` = $clog2(depth) with a minimum of 1.
- Sub-module `fifo_ext_ctrl` holds pointers, count, acceptance logic, status decode and error flags.
- Top level `fifo_flops_ext` holds the `mem` array and the `Dout` path per mode.

## Test plan
All scenarios use bits=16, depth=8, af_th=6, ae_th=1.
- Reset then idle: `count`=0, `pndng`=0, `full`=0, `almost_empty`=1, `almost_full`=0, `Dout`=0, both error flags 0.
- Push 0x0001..0x0008 on 8 consecutive cycles:
  - `almost_full` rises after the 6th push;
  - `full` rises after the 8th;
  - a 9th push of 0x0009 sets `overflow`, count stays 8.
  - Then pop 8 times: fwft=0 gives 0x0001..0x0008 in order, each one cycle after its pop.
- Fill to 8, then push 0xAAAA and pop together for 4 cycles: `count` stays 8, no `overflow`. Drain yields 0x0005..0x0008 then 0xAAAA ×4, exercising pointer wrap.
- Empty FIFO, pop with push of 0x1234 in the same cycle: `underflow`=1, `count`=1. fwft=1 shows 0x1234 on `Dout` next cycle. `clr_err` pulse clears `underflow`.
- Push 3 words, assert `rst` mid-push of a 4th: next cycle `count`=0, `pndng`=0. A subsequent push of 0xBEEF and pop returns 0xBEEF.
